// File: rtl/bp_be_branch_resolve.sv
// Branch resolution: compares resolved vs predicted next-PC, issues one redirect, squashes, drains.
// Optional statistics counters enabled by defining BP_BE_BRANCH_RESOLVE_STATS_EN.
module bp_be_branch_resolve #(
    parameter int vaddr_width_p  = 39,
    parameter int drain_cycles_p = 2,
    parameter int cnt_width_p    = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     br_v_i,
    input  logic                     br_branch_i,
    input  logic                     br_btaken_i,
    input  logic [vaddr_width_p-1:0] br_npc_i,
    input  logic [vaddr_width_p-1:0] pred_npc_i,
    output logic                     redirect_v_o,
    input  logic                     redirect_ready_i,
    output logic [vaddr_width_p-1:0] redirect_npc_o,
    output logic                     redirect_taken_o,
    output logic                     squash_o,
    output logic                     busy_o,
    output logic [cnt_width_p-1:0]   br_cnt_o,
    output logic [cnt_width_p-1:0]   mispred_cnt_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_REDIRECT, ST_DRAIN} state_e;

    state_e                   state_q, state_d;
    logic [vaddr_width_p-1:0] npc_q, npc_d;
    logic                     taken_q, taken_d;
    logic [3:0]               drain_q, drain_d;
    logic                     mispred;
    logic                     idle;

    assign mispred = br_v_i & (br_npc_i != pred_npc_i);
    assign idle    = (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        npc_d   = npc_q;
        taken_d = taken_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (mispred) begin
                    npc_d   = {br_npc_i[vaddr_width_p-1:1], 1'b0};
                    taken_d = br_btaken_i;
                    state_d = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                // Payload held until the frontend takes it; wrong-path packets ignored.
                if (redirect_ready_i) begin
                    if (drain_cycles_p == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        drain_d = 4'(drain_cycles_p - 1);
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == 4'd0) state_d = ST_IDLE;
                else                 drain_d = drain_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            npc_q   <= '0;
            taken_q <= 1'b0;
            drain_q <= 4'd0;
        end else begin
            state_q <= state_d;
            npc_q   <= npc_d;
            taken_q <= taken_d;
            drain_q <= drain_d;
        end
    end

    // Squash is combinational in IDLE so same-cycle younger work dies with the mispredict.
    assign squash_o         = idle ? mispred : 1'b1;
    assign redirect_v_o     = (state_q == ST_REDIRECT);
    assign busy_o           = !idle;
    assign redirect_npc_o   = npc_q;
    assign redirect_taken_o = taken_q;

`ifdef BP_BE_BRANCH_RESOLVE_STATS_EN
    logic [cnt_width_p-1:0] br_cnt_q, br_cnt_d;
    logic [cnt_width_p-1:0] mis_cnt_q, mis_cnt_d;

    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (idle && br_v_i && br_branch_i && !(&br_cnt_q)) br_cnt_d = br_cnt_q + 1'b1;
        if (idle && mispred && !(&mis_cnt_q))              mis_cnt_d = mis_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign br_cnt_o      = br_cnt_q;
    assign mispred_cnt_o = mis_cnt_q;
`else
    logic stats_unused;
    assign stats_unused  = br_branch_i;
    assign br_cnt_o      = '0;
    assign mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bp_be_branch_resolve.sv
// Directed bench: main instance with drain_cycles_p=2, second instance with drain_cycles_p=0.
module tb_bp_be_branch_resolve;
    localparam int W = 39;
    localparam int C = 32;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic         br_v_i, br_branch_i, br_btaken_i, redirect_ready_i;
    logic [W-1:0] br_npc_i, pred_npc_i;
    logic         redirect_v_o, redirect_taken_o, squash_o, busy_o;
    logic [W-1:0] redirect_npc_o;
    logic [C-1:0] br_cnt_o, mispred_cnt_o;

    logic         br_v0, ready0;
    logic         v0, taken0, sq0, busy0;
    logic [W-1:0] npc0;
    logic [C-1:0] bc0, mc0;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    bp_be_branch_resolve #(.vaddr_width_p(W), .drain_cycles_p(2), .cnt_width_p(C)) u_dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .br_v_i(br_v_i), .br_branch_i(br_branch_i),
        .br_btaken_i(br_btaken_i), .br_npc_i(br_npc_i), .pred_npc_i(pred_npc_i),
        .redirect_v_o(redirect_v_o), .redirect_ready_i(redirect_ready_i),
        .redirect_npc_o(redirect_npc_o), .redirect_taken_o(redirect_taken_o),
        .squash_o(squash_o), .busy_o(busy_o), .br_cnt_o(br_cnt_o), .mispred_cnt_o(mispred_cnt_o));

    bp_be_branch_resolve #(.vaddr_width_p(W), .drain_cycles_p(0), .cnt_width_p(C)) u_dut0 (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .br_v_i(br_v0), .br_branch_i(br_branch_i),
        .br_btaken_i(br_btaken_i), .br_npc_i(br_npc_i), .pred_npc_i(pred_npc_i),
        .redirect_v_o(v0), .redirect_ready_i(ready0),
        .redirect_npc_o(npc0), .redirect_taken_o(taken0),
        .squash_o(sq0), .busy_o(busy0), .br_cnt_o(bc0), .mispred_cnt_o(mc0));

    task automatic cyc();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        br_v_i = 0; br_v0 = 0; br_branch_i = 0; br_btaken_i = 0;
        redirect_ready_i = 0; ready0 = 0; br_npc_i = '0; pred_npc_i = '0;
        reset_n_i = 0;
        cyc();
        reset_n_i = 1;
        cyc();
    endtask

    task automatic test_reset();
        do_reset();
        reset_n_i = 0;
        #1;
        checks++;
        if ({redirect_v_o, redirect_taken_o, squash_o, busy_o} !== 4'b0 || redirect_npc_o !== '0) begin
            failures++;
            $display("FAIL reset_outputs: v=%b tk=%b sq=%b busy=%b npc=%h, required all 0",
                     redirect_v_o, redirect_taken_o, squash_o, busy_o, redirect_npc_o);
        end
        checks++;
        if (br_cnt_o !== '0 || mispred_cnt_o !== '0) begin
            failures++;
            $display("FAIL reset_counters: br=%0d mis=%0d, required 0 0", br_cnt_o, mispred_cnt_o);
        end
        cyc();
        reset_n_i = 1;
        cyc();
    endtask

    task automatic test_correct_predict();
        br_v_i = 1; br_branch_i = 1; br_btaken_i = 0;
        br_npc_i = 39'h8000_0004; pred_npc_i = 39'h8000_0004;
        #1;
        checks++;
        if (squash_o !== 1'b0) begin
            failures++;
            $display("FAIL correct_squash: got %b required 0", squash_o);
        end
        cyc();
        br_v_i = 0;
        #1;
        checks++;
        if (redirect_v_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL correct_noredirect: v=%b busy=%b required 0 0", redirect_v_o, busy_o);
        end
    endtask

    task automatic check_payload(input string nm, input logic [W-1:0] npc, input logic tk);
        checks++;
        if (redirect_v_o !== 1'b1 || redirect_npc_o !== npc || redirect_taken_o !== tk ||
            squash_o !== 1'b1 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL %s: v=%b npc=%h tk=%b sq=%b busy=%b, required 1 %h %b 1 1",
                     nm, redirect_v_o, redirect_npc_o, redirect_taken_o, squash_o, busy_o, npc, tk);
        end
    endtask

    task automatic test_mispredict_backpressure();
        br_v_i = 1; br_branch_i = 1; br_btaken_i = 1;
        br_npc_i = 39'h8000_0101; pred_npc_i = 39'h8000_0004; redirect_ready_i = 0;
        #1;
        checks++;
        if (squash_o !== 1'b1) begin
            failures++;
            $display("FAIL mispred_same_cycle_squash: got %b required 1", squash_o);
        end
        cyc();
        br_v_i = 0;
        #1;
        check_payload("mispred_redirect", 39'h8000_0100, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                br_v_i = 1; br_btaken_i = 0; br_npc_i = 39'h0000_1234; pred_npc_i = 39'h0000_0010;
            end else begin
                br_v_i = 0; br_btaken_i = 1;
            end
            cyc();
            check_payload("backpressure_hold", 39'h8000_0100, 1'b1);
        end
        br_v_i = 0;
        redirect_ready_i = 1;
        cyc();
        redirect_ready_i = 0;
        #1;
        checks++;
        if (redirect_v_o !== 1'b0 || squash_o !== 1'b1 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL drain_cycle1: v=%b sq=%b busy=%b required 0 1 1", redirect_v_o, squash_o, busy_o);
        end
        // Packet during the final DRAIN cycle must not be evaluated.
        br_v_i = 1; br_npc_i = 39'h0000_0ABC; pred_npc_i = 39'h0000_0000;
        cyc();
        checks++;
        if (squash_o !== 1'b1 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL drain_cycle2: sq=%b busy=%b required 1 1", squash_o, busy_o);
        end
        cyc();
        br_v_i = 0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || squash_o !== 1'b0 || redirect_v_o !== 1'b0) begin
            failures++;
            $display("FAIL drain_to_idle: busy=%b sq=%b v=%b required 0 0 0", busy_o, squash_o, redirect_v_o);
        end
        cyc();
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL boundary_packet_ignored: busy=%b required 0", busy_o);
        end
    endtask

    task automatic test_drain_zero();
        br_v0 = 1; br_btaken_i = 0;
        br_npc_i = 39'h2000_0003; pred_npc_i = 39'h0000_0000;
        #1;
        checks++;
        if (sq0 !== 1'b1) begin
            failures++;
            $display("FAIL d0_squash: got %b required 1", sq0);
        end
        cyc();
        br_v0 = 0; ready0 = 1;
        #1;
        checks++;
        if (v0 !== 1'b1 || npc0 !== 39'h2000_0002 || taken0 !== 1'b0) begin
            failures++;
            $display("FAIL d0_redirect: v=%b npc=%h tk=%b required 1 2000_0002 0", v0, npc0, taken0);
        end
        cyc();
        ready0 = 0;
        #1;
        checks++;
        if (v0 !== 1'b0 || busy0 !== 1'b0 || sq0 !== 1'b0) begin
            failures++;
            $display("FAIL d0_idle_after_hs: v=%b busy=%b sq=%b required 0 0 0", v0, busy0, sq0);
        end
        // Main instance also saw the shared packet? No: its br_v_i was low, so it must be idle.
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL d0_main_idle: busy=%b required 0", busy_o);
        end
    endtask

    task automatic wait_idle(input string nm);
        for (int k = 0; k < 20 && busy_o; k++) cyc();
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL %s_timeout: busy=%b required 0", nm, busy_o);
        end
    endtask

    task automatic test_reset_in_drain();
        br_v_i = 1; br_btaken_i = 1; br_npc_i = 39'h0000_0200; pred_npc_i = 39'h0000_0204;
        cyc();
        br_v_i = 0; redirect_ready_i = 1;
        cyc();
        redirect_ready_i = 0;
        reset_n_i = 0;
        #1;
        checks++;
        if ({redirect_v_o, redirect_taken_o, squash_o, busy_o} !== 4'b0 || redirect_npc_o !== '0) begin
            failures++;
            $display("FAIL reset_in_drain: v=%b tk=%b sq=%b busy=%b npc=%h required all 0",
                     redirect_v_o, redirect_taken_o, squash_o, busy_o, redirect_npc_o);
        end
        cyc();
        reset_n_i = 1;
        cyc();
        br_v_i = 1; br_btaken_i = 0; br_npc_i = 39'h40_0000_0041; pred_npc_i = 39'h40_0000_0044;
        cyc();
        br_v_i = 0; redirect_ready_i = 1;
        #1;
        check_payload("post_reset_redirect", 39'h40_0000_0040, 1'b0);
        cyc();
        redirect_ready_i = 0;
        wait_idle("post_reset_drain");
    endtask

    task automatic test_stats();
        logic [C-1:0] exp_br, exp_mis;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            br_v_i = 1;
            br_branch_i = (i != 10);
            br_btaken_i = 1;
            pred_npc_i = 39'h1000 + 39'(i * 16);
            br_npc_i   = (i == 2 || i == 5 || i == 8) ? pred_npc_i + 39'h20 : pred_npc_i;
            cyc();
            br_v_i = 0; redirect_ready_i = 1;
            wait_idle("stats_drain");
            redirect_ready_i = 0;
        end
`ifdef BP_BE_BRANCH_RESOLVE_STATS_EN
        exp_br = 10; exp_mis = 3;
`else
        exp_br = 0; exp_mis = 0;
`endif
        checks++;
        if (br_cnt_o !== exp_br) begin
            failures++;
            $display("FAIL stats_br_cnt: got %0d required %0d", br_cnt_o, exp_br);
        end
        checks++;
        if (mispred_cnt_o !== exp_mis) begin
            failures++;
            $display("FAIL stats_mispred_cnt: got %0d required %0d", mispred_cnt_o, exp_mis);
        end
    endtask

    initial begin
        test_reset();
        test_correct_predict();
        test_mispredict_backpressure();
        test_drain_zero();
        test_reset_in_drain();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
